// File: rtl/usb_reg_bridge.sv
// usb_reg_bridge: USB MCU parallel bus to internal register bus bridge.
// Synchronises the cwusb_* strobes into clk_usb, latches address, and runs a
// read/write/turnaround FSM with programmable read latency and output hold.
// Optional: define USB_REG_PROTERR_EN to enable the protocol error counter.
module usb_reg_bridge #(
    parameter int pADDR_WIDTH   = 8,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pSYNC_STAGES  = 2,
    parameter int pRD_LATENCY   = 1,
    parameter int pHOLD_CYCLES  = 2,
    parameter int pBYTECNT_WRAP = 1
) (
    input  logic                     clk_usb,
    input  logic                     reset,
    input  logic [7:0]               cwusb_din,
    output logic [7:0]               cwusb_dout,
    output logic                     cwusb_isout,
    input  logic [pADDR_WIDTH-1:0]   cwusb_addr,
    input  logic                     cwusb_rdn,
    input  logic                     cwusb_wrn,
    input  logic                     cwusb_cen,
    input  logic                     cwusb_alen,
    input  logic                     I_drive_data,
    output logic [pADDR_WIDTH-1:0]   reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    output logic [7:0]               err_count
);
    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_HOLD, TURN, ERR} state_t;

    localparam logic [7:0]               LAT_LAST  = 8'(pRD_LATENCY);
    localparam logic [7:0]               HOLD_LAST = 8'(pHOLD_CYCLES - 1);
    localparam logic [pBYTECNT_SIZE-1:0] BC_MAX    = '1;

    // strobes {rdn,wrn,cen,alen}; address and data travel alongside so they
    // line up with the synchronised strobes
    logic [pSYNC_STAGES-1:0][3:0]             strb_q;
    logic [pSYNC_STAGES-1:0][pADDR_WIDTH-1:0] addr_q;
    logic [pSYNC_STAGES-1:0][7:0]             din_q;

    // synchroniser chains, idle-high strobes after reset
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            strb_q <= '1;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            strb_q <= {strb_q[pSYNC_STAGES-2:0], {cwusb_rdn, cwusb_wrn, cwusb_cen, cwusb_alen}};
            addr_q <= {addr_q[pSYNC_STAGES-2:0], cwusb_addr};
            din_q  <= {din_q[pSYNC_STAGES-2:0], cwusb_din};
        end
    end

    logic rd, wr, al;
    assign rd = ~strb_q[pSYNC_STAGES-1][3] & ~strb_q[pSYNC_STAGES-1][1];
    assign wr = ~strb_q[pSYNC_STAGES-1][2] & ~strb_q[pSYNC_STAGES-1][1];
    assign al = ~strb_q[pSYNC_STAGES-1][0];

    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gone_q, gone_d;
    logic       rd_pulse, wr_pulse, cap, rd_done;

    // next-state: TURN shares the IDLE decode so a new strobe aborts the hold
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gone_d   = gone_q;
        rd_pulse = 1'b0;
        wr_pulse = 1'b0;
        cap      = 1'b0;
        rd_done  = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (state_q == TURN) begin
                    if (cnt_q == HOLD_LAST) state_d = IDLE;
                    else                    cnt_d   = cnt_q + 8'd1;
                end
                if (rd && wr) begin
                    state_d = ERR;
                end else if (wr) begin
                    state_d = WR;
                end else if (rd) begin
                    state_d  = RD_WAIT;
                    rd_pulse = 1'b1;
                    cnt_d    = '0;
                    gone_d   = 1'b0;
                end
            end
            WR: begin
                if (!wr) begin
                    wr_pulse = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_WAIT: begin
                if (!rd) gone_d = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    cap = 1'b1;
                    if (gone_q || !rd) begin
                        state_d = TURN;
                        cnt_d   = '0;
                        rd_done = 1'b1;
                    end else begin
                        state_d = RD_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_HOLD: begin
                if (!rd) begin
                    state_d = TURN;
                    cnt_d   = '0;
                    rd_done = 1'b1;
                end
            end
            ERR: begin
                if (!rd && !wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic                     rd_q, wr_q, isout_q, av_q;
    logic [7:0]               dout_q, datao_q;
    logic [pADDR_WIDTH-1:0]   raddr_q;
    logic [pBYTECNT_SIZE-1:0] bc_q, bc_inc;
    logic                     al_prev_q;

    assign bc_inc = (bc_q == BC_MAX) ? ((pBYTECNT_WRAP != 0) ? '0 : BC_MAX)
                                     : bc_q + 1'b1;

    // FSM state, pulses, data capture and address tracking
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gone_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            isout_q   <= 1'b0;
            dout_q    <= '0;
            datao_q   <= '0;
            raddr_q   <= '0;
            bc_q      <= '0;
            av_q      <= 1'b0;
            al_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gone_q    <= gone_d;
            rd_q      <= rd_pulse;
            wr_q      <= wr_pulse;
            isout_q   <= (state_d == RD_WAIT) || (state_d == RD_HOLD) || (state_d == TURN);
            al_prev_q <= al;
            if (cap)             dout_q  <= reg_datai;
            if (state_q == WR)   datao_q <= din_q[pSYNC_STAGES-1];
            // address latch clears the byte index ahead of any increment
            if (al) begin
                raddr_q <= addr_q[pSYNC_STAGES-1];
                bc_q    <= '0;
                av_q    <= 1'b0;
            end else begin
                if (al_prev_q)       av_q <= 1'b1;
                if (wr_q || rd_done) bc_q <= bc_inc;
            end
        end
    end

`ifdef USB_REG_PROTERR_EN
    logic [7:0] err_q;
    logic       wr_prev_q;

    // count ERR entries and writes that collide with a read in progress
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            err_q     <= '0;
            wr_prev_q <= 1'b0;
        end else begin
            wr_prev_q <= wr;
            if ((err_q != 8'hFF) &&
                (((state_d == ERR) && (state_q != ERR)) ||
                 (wr && !wr_prev_q && ((state_q == RD_WAIT) || (state_q == RD_HOLD)))))
                err_q <= err_q + 8'd1;
        end
    end
    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif

    assign cwusb_dout    = dout_q;
    assign cwusb_isout   = isout_q | I_drive_data;
    assign reg_address   = raddr_q;
    assign reg_bytecnt   = bc_q;
    assign reg_datao     = datao_q;
    assign reg_read      = rd_q;
    assign reg_write     = wr_q;
    assign reg_addrvalid = av_q;
endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed bench for usb_reg_bridge: two instances (byte counter wrap and
// saturate) with 2 sync stages, read latency 3, hold 2, 3-bit byte counter.
module tb_usb_reg_bridge;
    logic       clk_usb = 1'b0;
    logic       reset;
    logic [7:0] cwusb_din, reg_datai, cwusb_addr;
    logic       cwusb_rdn, cwusb_wrn, cwusb_cen, cwusb_alen, I_drive_data;

    logic [7:0] dout_a, dout_b, addr_a, addr_b, datao_a, datao_b, errc_a, errc_b;
    logic [2:0] bc_a, bc_b;
    logic       isout_a, isout_b, rdp_a, rdp_b, wrp_a, wrp_b, av_a, av_b;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int rd_base, wr_base;

`ifdef USB_REG_PROTERR_EN
    localparam logic [7:0] ERR_EXP = 8'd1;
`else
    localparam logic [7:0] ERR_EXP = 8'd0;
`endif

    always #5 clk_usb = ~clk_usb;

    usb_reg_bridge #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(3), .pSYNC_STAGES(2),
                     .pRD_LATENCY(3), .pHOLD_CYCLES(2), .pBYTECNT_WRAP(1)) u_a (
        .clk_usb(clk_usb), .reset(reset), .cwusb_din(cwusb_din), .cwusb_dout(dout_a),
        .cwusb_isout(isout_a), .cwusb_addr(cwusb_addr), .cwusb_rdn(cwusb_rdn),
        .cwusb_wrn(cwusb_wrn), .cwusb_cen(cwusb_cen), .cwusb_alen(cwusb_alen),
        .I_drive_data(I_drive_data), .reg_address(addr_a), .reg_bytecnt(bc_a),
        .reg_datao(datao_a), .reg_datai(reg_datai), .reg_read(rdp_a), .reg_write(wrp_a),
        .reg_addrvalid(av_a), .err_count(errc_a));

    usb_reg_bridge #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(3), .pSYNC_STAGES(2),
                     .pRD_LATENCY(3), .pHOLD_CYCLES(2), .pBYTECNT_WRAP(0)) u_b (
        .clk_usb(clk_usb), .reset(reset), .cwusb_din(cwusb_din), .cwusb_dout(dout_b),
        .cwusb_isout(isout_b), .cwusb_addr(cwusb_addr), .cwusb_rdn(cwusb_rdn),
        .cwusb_wrn(cwusb_wrn), .cwusb_cen(cwusb_cen), .cwusb_alen(cwusb_alen),
        .I_drive_data(I_drive_data), .reg_address(addr_b), .reg_bytecnt(bc_b),
        .reg_datao(datao_b), .reg_datai(reg_datai), .reg_read(rdp_b), .reg_write(wrp_b),
        .reg_addrvalid(av_b), .err_count(errc_b));

    // pulse counters for instance a, sampled mid-cycle
    always @(negedge clk_usb) begin
        if (rdp_a) rd_pulses++;
        if (wrp_a) wr_pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one write; reg_write lands 3 edges after wrn rises, bytecnt steps a cycle later
    task automatic do_write(input logic [7:0] d, input logic [2:0] ea0, input logic [2:0] eb0,
                            input logic [2:0] ea1, input logic [2:0] eb1);
        cwusb_din = d; cwusb_wrn = 1'b0; step(3);
        cwusb_wrn = 1'b1; step(2);
        chk("wr_not_yet", wrp_a, 1'b0);
        step(1);
        chk("wr_pulse_a", wrp_a, 1'b1);
        chk("wr_pulse_b", wrp_b, 1'b1);
        chk("wr_datao_a", datao_a, d);
        chk("wr_datao_b", datao_b, d);
        chk("wr_bc_pre_a", bc_a, ea0);
        chk("wr_bc_pre_b", bc_b, eb0);
        step(1);
        chk("wr_pulse_end", wrp_a, 1'b0);
        chk("wr_bc_post_a", bc_a, ea1);
        chk("wr_bc_post_b", bc_b, eb1);
        cwusb_din = 8'hEE; step(2);
    endtask

    task automatic do_read();
        cwusb_rdn = 1'b0; step(8);
        cwusb_rdn = 1'b1; step(6);
    endtask

    initial begin
        reset = 1'b1; cwusb_din = '0; reg_datai = '0; cwusb_addr = '0;
        cwusb_rdn = 1'b1; cwusb_wrn = 1'b1; cwusb_cen = 1'b1; cwusb_alen = 1'b1;
        I_drive_data = 1'b0;
        step(3);
        chk("rst_isout", isout_a, 1'b0);
        chk("rst_dout", dout_a, 8'h00);
        chk("rst_bc", bc_a, 3'd0);
        chk("rst_av", av_a, 1'b0);
        chk("rst_rd", rdp_a, 1'b0);
        chk("rst_wr", wrp_a, 1'b0);
        chk("rst_addr", addr_a, 8'h00);
        chk("rst_errc", errc_a, 8'h00);
        reset = 1'b0; cwusb_cen = 1'b0; step(2);

        // address latch 0x2A; addrvalid rises 3 edges after alen rises
        cwusb_addr = 8'h2A; cwusb_alen = 1'b0; step(4);
        cwusb_alen = 1'b1; cwusb_addr = 8'h00; step(2);
        chk("av_not_yet", av_a, 1'b0);
        step(1);
        chk("av_set", av_a, 1'b1);
        chk("addr_2a", addr_a, 8'h2A);

        // three-byte write burst
        do_write(8'h11, 3'd0, 3'd0, 3'd1, 3'd1);
        do_write(8'h22, 3'd1, 3'd1, 3'd2, 3'd2);
        do_write(8'h33, 3'd2, 3'd2, 3'd3, 3'd3);
        chk("addr_after_wr", addr_a, 8'h2A);

        // latency-3 read: 0xA5 valid only in the 3rd cycle after reg_read
        reg_datai = 8'h5A; cwusb_rdn = 1'b0; step(2);
        chk("rd_not_yet", rdp_a, 1'b0);
        step(1);
        chk("rd_pulse", rdp_a, 1'b1);
        step(1);
        chk("rd_pulse_end", rdp_a, 1'b0);
        chk("rd_isout", isout_a, 1'b1);
        step(2);
        reg_datai = 8'hA5; step(1);
        reg_datai = 8'hFF;
        chk("rd_capture", dout_a, 8'hA5);
        step(3);
        chk("rd_hold_dout", dout_a, 8'hA5);
        chk("rd_hold_bc", bc_a, 3'd3);
        cwusb_rdn = 1'b1; step(4);
        chk("turn_isout", isout_a, 1'b1);
        chk("turn_bc", bc_a, 3'd4);
        step(1);
        chk("turn_done", isout_a, 1'b0);
        chk("rd_dout_kept", dout_a, 8'hA5);

        // back-to-back read entering during TURN keeps isout high
        rd_base = rd_pulses; reg_datai = 8'h3C;
        cwusb_rdn = 1'b0; step(8);
        cwusb_rdn = 1'b1; step(1);
        cwusb_rdn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("turn_rerd_isout", isout_a, 1'b1);
        end
        cwusb_rdn = 1'b1; step(6);
        chk("rerd_pulses", rd_pulses - rd_base, 2);
        chk("rerd_bc_a", bc_a, 3'd6);
        chk("rerd_dout", dout_a, 8'h3C);
        chk("rerd_isout_off", isout_a, 1'b0);

        // relatch 0x55 clears bytecnt, then 9 reads: wrap vs saturate
        cwusb_addr = 8'h55; cwusb_alen = 1'b0; step(3);
        chk("relatch_av_clr", av_a, 1'b0);
        chk("relatch_bc_clr", bc_a, 3'd0);
        step(1);
        cwusb_alen = 1'b1; cwusb_addr = 8'h00; step(3);
        chk("relatch_av", av_a, 1'b1);
        chk("relatch_addr", addr_a, 8'h55);
        for (int i = 0; i < 9; i++) do_read();
        chk("wrap_bc", bc_a, 3'd1);
        chk("sat_bc", bc_b, 3'd7);

        // rdn and wrn together: no pulses, then recovery
        rd_base = rd_pulses; wr_base = wr_pulses;
        cwusb_rdn = 1'b0; cwusb_wrn = 1'b0; step(6);
        chk("err_no_rd", rd_pulses - rd_base, 0);
        chk("err_no_wr", wr_pulses - wr_base, 0);
        chk("err_isout", isout_a, 1'b0);
        chk("err_count", errc_a, ERR_EXP);
        cwusb_rdn = 1'b1; cwusb_wrn = 1'b1; step(4);
        do_write(8'h77, 3'd1, 3'd7, 3'd2, 3'd7);

        // reset asserted while holding read data
        reg_datai = 8'h99; cwusb_rdn = 1'b0; step(8);
        chk("hold_dout", dout_a, 8'h99);
        chk("hold_isout", isout_a, 1'b1);
        reset = 1'b1; cwusb_rdn = 1'b1; step(1);
        chk("midrst_isout", isout_a, 1'b0);
        chk("midrst_dout", dout_a, 8'h00);
        chk("midrst_bc_a", bc_a, 3'd0);
        chk("midrst_bc_b", bc_b, 3'd0);
        chk("midrst_av", av_a, 1'b0);
        reset = 1'b0; step(3);

        // I_drive_data forces the bus direction combinationally
        I_drive_data = 1'b1; #1;
        chk("drive_isout", isout_a, 1'b1);
        I_drive_data = 1'b0; #1;
        chk("drive_off", isout_a, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
